block_ram_packing_fifo: RTL
===========================

# block_ram_packing_fifo

Ready/valid FIFO that packs a stream of DATA_WIDTH words into NUM_WORDS-wide rows stored in block RAM and returns whole rows on a first-word-fall-through read port. It sits between narrow per-pixel/per-channel producers and wide consumers such as convolution line buffers and weight loaders. It adds the following over a plain multi-word RAM:
- lane-packing write pointer
- early row close (`wr_last`) with a per-row valid-word count
- full/empty flow control
- a backpressure-safe read pipeline

## Interface
- `DATA_WIDTH`, 8, width of one word
- `DEPTH`, 64, rows of storage; power of two, ≥ 2
- `NUM_WORDS`, 4, words (lanes) per row; ≥ 2
- `RAM_STYLE`, "auto", synthesis ram_style attribute for row storage
- `OUTPUT_REGISTER`, "false", "true" adds one register stage after the RAM read

- `clk`  in  1  sole clock; all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `wr_data`  in  DATA_WIDTH  word to pack
- `wr_valid`  in  1  `wr_data` valid
- `wr_last`  in  1  qualifies `wr_valid`; closes current row after this word
- `wr_ready`  out  1  word accepted when `wr_valid && wr_ready`
- `rd_data`  out  DATA_WIDTH*NUM_WORDS  row; lane 0 = first word written, at [DATA_WIDTH-1:0]
- `rd_words`  out  $clog2(NUM_WORDS+1)  valid lanes in `rd_data`, 1..NUM_WORDS
- `rd_valid`  out  1  row available
- `rd_ready`  in  1  row consumed when `rd_valid && rd_ready`
- `count`  out  $clog2(DEPTH)+1  committed rows not yet consumed, 0..DEPTH

## Operation
- Write handshake: write `wr_data` into lane `lane_idx` of row `wr_ptr` using a per-lane write enable, then advance `lane_idx`.
- Commit: a row commits on the handshake where `lane_idx == NUM_WORDS-1` or `wr_last == 1`. On commit:
  - store `lane_idx+1` in the side array `words[wr_ptr]`
  - `lane_idx` returns to 0
  - `wr_ptr` increments mod DEPTH
- Unwritten lanes of a row closed early hold stale data. Consumers honour `rd_words`.
- `wr_ready` = (`count` < DEPTH). A partial row in progress occupies the free slot at `wr_ptr`.
- Read engine: issue a RAM read of `rd_ptr` (then increment `rd_ptr` mod DEPTH) when:
  - rows are committed but not yet issued, and
  - the output queue has a free credit.
- Output queue: LAT entries, where LAT = 1 + (OUTPUT_REGISTER == "true"), plus one skid entry. Rows are returned in order and never dropped or duplicated under any `rd_ready` pattern.
- `count`:
  - +1 on commit
  - −1 on read handshake
  - unchanged when both happen in the same cycle
- Empty: `rd_valid` = 0 and `rd_data`/`rd_words` hold their last values.
- Pointer wrap: DEPTH−1 → 0 on both sides, no gap.
- Reset (any cycle, including mid-row or mid-read) clears all of the following; RAM contents are not reset, and a partially packed row is discarded:
  - `wr_ptr`, `rd_ptr`, `lane_idx`
  - `count`
  - issue counter, output queue
- Reset values: `wr_ready` = 1, `rd_valid` = 0, `count` = 0, `rd_data` = 0, `rd_words` = 0.

## Timing
- Write side: one word per cycle sustained while `count` < DEPTH.
- Commit latency, empty queue: if the row commits at edge t, `rd_valid` rises after edge t+1+LAT.
  - "false": commit edge, then 2 edges
  - "true": commit edge, then 3 edges
- Read throughput: one row per cycle while `rd_ready` = 1 and rows are available.
- Backpressure: `rd_valid`, `rd_data` and `rd_words` stay stable while `rd_valid && !rd_ready`.
- Full: `wr_ready` drops in the cycle after the commit that makes `count` = DEPTH, and rises in the cycle after the next read handshake.
- Commit and read handshake in the same cycle at `count` = DEPTH: `wr_ready` stays 0.

## Structure
- Shared package holds:
  - `lane_idx_w` = $clog2(NUM_WORDS)
  - `ptr_w` = $clog2(DEPTH)
  - `words_w` = $clog2(NUM_WORDS+1)
  - `read_latency(OUTPUT_REGISTER)`, returning LAT
- Sub-module `block_ram_multi_word_sdp`: simple dual-port RAM with per-lane write enables, a read enable and the optional output register, carrying `RAM_STYLE`. It contains no control logic.
- The `words` side array lives in distributed registers beside the RAM and is read in lockstep with it.

## Test plan
- DATA_WIDTH=8, NUM_WORDS=4, `rd_ready`=1, write 0x01..0x08 → two rows, 0x04030201 then 0x08070605, `rd_words`=4; first `rd_valid` two edges after commit ("false") or three ("true").
- Write 0xAA with `wr_last`=1, then 0x11..0x14 → row 1 lane 0 = 0xAA with `rd_words`=1; row 2 = 0x14131211 with `rd_words`=4.
- DEPTH=4, `rd_ready`=0, write 16 words → `count`=4, `wr_ready`=0 after the 4th commit; a 17th `wr_valid` is not accepted. Pulse `rd_ready` once → `count`=3, `wr_ready`=1 the next cycle.
- Random `wr_valid`/`rd_ready` over 10·DEPTH rows (forces pointer wrap) → scoreboard matches in order; `rd_data` stable whenever `rd_valid && !rd_ready`.
- Assert `rst_n`=0 mid-row with `count`=2 → outputs return to reset values immediately; after release, a new write of 0x05..0x08 yields 0x08070605 as the first row.

Source files
------------

// File: rtl/block_ram_packing_fifo_pkg.sv
// Shared width helpers and read-latency function for the packing FIFO and its RAM.
package block_ram_packing_fifo_pkg;

  function automatic int lane_idx_w(input int num_words);
    return $clog2(num_words);
  endfunction

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int words_w(input int num_words);
    return $clog2(num_words + 1);
  endfunction

  // RAM read register, plus the optional output register
  function automatic int read_latency(input bit out_reg);
    return out_reg ? 2 : 1;
  endfunction

endpackage

// File: rtl/block_ram_packing_fifo_if.sv
// Write/read handshake bundle of the packing FIFO; master = producer/consumer, slave = FIFO.
interface block_ram_packing_fifo_if
  import block_ram_packing_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_WORDS  = 4,
  parameter int DEPTH      = 64
);

  logic [DATA_WIDTH-1:0]                 wr_data;
  logic                                  wr_valid;
  logic                                  wr_last;
  logic                                  wr_ready;
  // lane 0 (first word of the row) sits in the low bits
  logic [NUM_WORDS-1:0][DATA_WIDTH-1:0]  rd_data;
  logic [words_w(NUM_WORDS)-1:0]         rd_words;
  logic                                  rd_valid;
  logic                                  rd_ready;
  logic [ptr_w(DEPTH):0]                 count;

  modport master (
    output wr_data, wr_valid, wr_last, rd_ready,
    input  wr_ready, rd_data, rd_words, rd_valid, count
  );

  modport slave (
    input  wr_data, wr_valid, wr_last, rd_ready,
    output wr_ready, rd_data, rd_words, rd_valid, count
  );

endinterface

// File: rtl/block_ram_multi_word_sdp.sv
// Simple dual-port RAM, one independent column per lane with its own write enable;
// registered read with an optional second output register. No control logic.
module block_ram_multi_word_sdp #(
  parameter int    DATA_WIDTH = 8,
  parameter int    NUM_WORDS  = 4,
  parameter int    DEPTH      = 64,
  parameter string RAM_STYLE  = "auto",
  parameter bit    OUT_REG    = 1'b0
) (
  input  logic                                 clk,
  input  logic [NUM_WORDS-1:0]                 i_we,
  input  logic [$clog2(DEPTH)-1:0]             i_waddr,
  input  logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] i_wdata,
  input  logic                                 i_re,
  input  logic [$clog2(DEPTH)-1:0]             i_raddr,
  output logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] o_rdata
);

  for (genvar l = 0; l < NUM_WORDS; l++) begin : g_lane
    (* ram_style = RAM_STYLE *) logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
      if (i_we[l]) r_mem[i_waddr] <= i_wdata[l];
      if (i_re)    r_q            <= r_mem[i_raddr];
    end

    if (OUT_REG) begin : g_oreg
      logic [DATA_WIDTH-1:0] r_q2;
      always_ff @(posedge clk) r_q2 <= r_q;
      assign o_rdata[l] = r_q2;
    end else begin : g_direct
      assign o_rdata[l] = r_q;
    end
  end

endmodule

// File: rtl/block_ram_packing_fifo.sv
// Packs DATA_WIDTH words into NUM_WORDS-lane rows in block RAM and returns whole rows
// through a credit-controlled, first-word-fall-through output queue.
module block_ram_packing_fifo
  import block_ram_packing_fifo_pkg::*;
#(
  parameter int    DATA_WIDTH      = 8,
  parameter int    DEPTH           = 64,
  parameter int    NUM_WORDS       = 4,
  parameter string RAM_STYLE       = "auto",
  parameter string OUTPUT_REGISTER = "false"
) (
  input  logic                     clk,
  input  logic                     rst_n,
  block_ram_packing_fifo_if.slave  bus
);

  localparam int LW   = lane_idx_w(NUM_WORDS);
  localparam int PW   = ptr_w(DEPTH);
  localparam int WW   = words_w(NUM_WORDS);
  localparam bit OREG = (OUTPUT_REGISTER == "true");
  localparam int LAT  = read_latency(OREG);
  localparam int CAP  = LAT + 1;

  typedef logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] row_t;

  logic [LW-1:0]        r_lane;
  logic [PW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [PW:0]          r_count, r_pending;
  logic [1:0]           r_credits;
  logic [LAT-1:0]       r_vld_pipe;
  logic [LAT:0]         w_vld_pipe;

  logic                 w_wr_hs, w_commit, w_pop, w_re, w_arr;
  logic [NUM_WORDS-1:0] w_we;
  row_t                 w_wdata, w_ram_q;

  logic [WW-1:0]        r_words [DEPTH];
  logic [WW-1:0]        r_wrd_s1, r_wrd_s2, w_arr_words;

  logic                 r_out_vld;
  row_t                 r_out_data;
  logic [WW-1:0]        r_out_words;
  row_t                 r_q_data  [2];
  logic [WW-1:0]        r_q_words [2];
  logic                 r_q_rd, r_q_wr;
  logic [1:0]           r_q_cnt;
  logic                 w_load, w_from_q, w_from_arr, w_q_push;

  // ---------------- write side ----------------
  // The in-progress partial row owns the slot at r_wr_ptr, so full means count == DEPTH.
  assign bus.wr_ready = (r_count < (PW+1)'(DEPTH));
  assign w_wr_hs      = bus.wr_valid && bus.wr_ready;
  assign w_commit     = w_wr_hs && ((r_lane == LW'(NUM_WORDS-1)) || bus.wr_last);
  assign w_wdata      = {NUM_WORDS{bus.wr_data}};

  always_comb begin
    w_we = '0;
    if (w_wr_hs) w_we[r_lane] = 1'b1;
  end

  // ---------------- read engine ----------------
  // Credits cover queue entries plus reads in flight; a same-cycle pop frees one.
  assign w_pop      = r_out_vld && bus.rd_ready;
  assign w_re       = (r_pending != '0) && ((r_credits < 2'(CAP)) || w_pop);
  assign w_vld_pipe = {r_vld_pipe, w_re};
  assign w_arr      = w_vld_pipe[LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane     <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_pending  <= '0;
      r_credits  <= '0;
      r_vld_pipe <= '0;
    end else begin
      if (w_wr_hs)  r_lane   <= w_commit ? '0 : r_lane + 1'b1;
      if (w_commit) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_re)     r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_commit, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
      case ({w_commit, w_re})
        2'b10:   r_pending <= r_pending + 1'b1;
        2'b01:   r_pending <= r_pending - 1'b1;
        default: ;
      endcase
      case ({w_re, w_pop})
        2'b10:   r_credits <= r_credits + 1'b1;
        2'b01:   r_credits <= r_credits - 1'b1;
        default: ;
      endcase
      r_vld_pipe <= w_vld_pipe[LAT-1:0];
    end
  end

  // Word counts live beside the RAM and follow the same read pipeline.
  always_ff @(posedge clk) begin
    if (w_commit) r_words[r_wr_ptr] <= WW'(r_lane) + 1'b1;
    if (w_re)     r_wrd_s1          <= r_words[r_rd_ptr];
    r_wrd_s2 <= r_wrd_s1;
  end

  assign w_arr_words = OREG ? r_wrd_s2 : r_wrd_s1;

  block_ram_multi_word_sdp #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_WORDS  (NUM_WORDS),
    .DEPTH      (DEPTH),
    .RAM_STYLE  (RAM_STYLE),
    .OUT_REG    (OREG)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_re    (w_re),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_ram_q)
  );

  // ---------------- output queue ----------------
  // Head register drives the port; up to LAT older arrivals wait in a small ring behind it.
  assign w_load     = !r_out_vld || w_pop;
  assign w_from_q   = w_load && (r_q_cnt != 2'd0);
  assign w_from_arr = w_load && (r_q_cnt == 2'd0) && w_arr;
  assign w_q_push   = w_arr && !w_from_arr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld   <= 1'b0;
      r_out_data  <= '0;
      r_out_words <= '0;
      r_q_rd      <= 1'b0;
      r_q_wr      <= 1'b0;
      r_q_cnt     <= '0;
    end else begin
      if (w_load) r_out_vld <= (r_q_cnt != 2'd0) || w_arr;
      if (w_from_q) begin
        r_out_data  <= r_q_data[r_q_rd];
        r_out_words <= r_q_words[r_q_rd];
        r_q_rd      <= (LAT == 1) ? 1'b0 : ~r_q_rd;
      end else if (w_from_arr) begin
        r_out_data  <= w_ram_q;
        r_out_words <= w_arr_words;
      end
      if (w_q_push) r_q_wr <= (LAT == 1) ? 1'b0 : ~r_q_wr;
      case ({w_q_push, w_from_q})
        2'b10:   r_q_cnt <= r_q_cnt + 1'b1;
        2'b01:   r_q_cnt <= r_q_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_q_push) begin
      r_q_data[r_q_wr]  <= w_ram_q;
      r_q_words[r_q_wr] <= w_arr_words;
    end
  end

  assign bus.rd_valid = r_out_vld;
  assign bus.rd_data  = r_out_data;
  assign bus.rd_words = r_out_words;
  assign bus.count    = r_count;

endmodule
